// File: rtl/tick_counter_pkg.sv
// Shared helpers for tick_counter: load clamping and prescaler width sizing.
package tick_counter_pkg;

    // Prescaler width: $clog2(div) but never below one bit.
    function automatic int unsigned pre_width(input int unsigned div);
        return (div <= 32'd2) ? 32'd1 : 32'($clog2(div));
    endfunction

    // Out-of-range load values land on the top of the count range.
    function automatic int unsigned clamp_load(input int unsigned val, input int unsigned modulo);
        return (val < modulo) ? val : (modulo - 32'd1);
    endfunction

endpackage

// File: rtl/tick_counter_if.sv
// Control and status bundle of tick_counter.
interface tick_counter_if #(
    parameter int unsigned WIDTH = 5
) ();
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] out;
    logic             tick;
    logic             tc;

    modport master (
        output en, up, load, load_val,
        input  out, tick, tc
    );

    modport slave (
        input  en, up, load, load_val,
        output out, tick, tc
    );
endinterface

// File: rtl/tick_gen.sv
// Prescaler: free-running modulo-DIV phase counter with a one-cycle strobe at DIV-1.
module tick_gen #(
    parameter int unsigned DIV   = 4,
    parameter int unsigned PRE_W = 2
) (
    input  logic clk_in,
    input  logic rst,
    input  logic restart,
    output logic stb
);
    logic [PRE_W-1:0] pre;

    assign stb = (pre == PRE_W'(DIV - 32'd1));

    // Restart realigns the tick phase to the current edge.
    always_ff @(posedge clk_in) begin
        if (rst || restart || stb) begin
            pre <= '0;
        end else begin
            pre <= pre + PRE_W'(1);
        end
    end
endmodule

// File: rtl/tick_counter.sv
// Prescaled up/down modulo counter with synchronous load and terminal-count pulse.
// Define TICK_COUNTER_SAT_EN to saturate at the range ends instead of wrapping.
module tick_counter
    import tick_counter_pkg::*;
#(
    parameter int unsigned WIDTH  = 5,
    parameter int unsigned MODULO = 32,
    parameter int unsigned DIV    = 4194304,
    parameter int unsigned PRE_W  = pre_width(DIV)
) (
    input  logic          clk_in,
    input  logic          rst,
    tick_counter_if.slave bus
);
    localparam longint unsigned SPAN = 64'(1) << WIDTH;
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 32'd1);

    if ((MODULO < 32'd2) || (64'(MODULO) > SPAN)) begin : g_bad_modulo
        $error("tick_counter: MODULO out of range 2..2**WIDTH");
    end
    if (DIV < 32'd1) begin : g_bad_div
        $error("tick_counter: DIV must be >= 1");
    end

    logic             stb;
    logic [WIDTH-1:0] out_q, out_nxt;
    logic             tick_q, tick_nxt;
    logic             tc_q, tc_nxt;
    logic [WIDTH-1:0] load_clamped;

    tick_gen #(
        .DIV   (DIV),
        .PRE_W (PRE_W)
    ) u_tick_gen (
        .clk_in  (clk_in),
        .rst     (rst),
        .restart (bus.load),
        .stb     (stb)
    );

    assign load_clamped = WIDTH'(clamp_load(32'(bus.load_val), MODULO));

    // Next count: load wins over a step; ends wrap (or hold when saturating) with tc.
    always_comb begin
        out_nxt  = out_q;
        tc_nxt   = 1'b0;
        tick_nxt = stb;
        if (bus.load) begin
            out_nxt  = load_clamped;
            tick_nxt = 1'b0;
        end else if (stb && bus.en) begin
            if (bus.up) begin
                if (out_q == MAX_VAL) begin
                    tc_nxt = 1'b1;
`ifdef TICK_COUNTER_SAT_EN
                    out_nxt = out_q;
`else
                    out_nxt = '0;
`endif
                end else begin
                    out_nxt = out_q + WIDTH'(1);
                end
            end else begin
                if (out_q == '0) begin
                    tc_nxt = 1'b1;
`ifdef TICK_COUNTER_SAT_EN
                    out_nxt = out_q;
`else
                    out_nxt = MAX_VAL;
`endif
                end else begin
                    out_nxt = out_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            out_q  <= '0;
            tick_q <= 1'b0;
            tc_q   <= 1'b0;
        end else begin
            out_q  <= out_nxt;
            tick_q <= tick_nxt;
            tc_q   <= tc_nxt;
        end
    end

    assign bus.out  = out_q;
    assign bus.tick = tick_q;
    assign bus.tc   = tc_q;
endmodule

// File: tb/tb_tick_counter.sv
// Directed bench for tick_counter (WIDTH=5, MODULO=10, DIV=4) plus a DIV=1 instance.
module tb_tick_counter;

    logic clk_in = 1'b0;
    logic rst    = 1'b1;
    logic rst1   = 1'b1;
    int   total  = 0;
    int   bad    = 0;

    always #5 clk_in = ~clk_in;

    tick_counter_if #(.WIDTH(5)) bus  ();
    tick_counter_if #(.WIDTH(5)) bus1 ();

    tick_counter #(.WIDTH(5), .MODULO(10), .DIV(4)) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bus.slave)
    );

    tick_counter #(.WIDTH(5), .MODULO(10), .DIV(1)) dut1 (
        .clk_in (clk_in),
        .rst    (rst1),
        .bus    (bus1.slave)
    );

    typedef struct {
        logic       rst;
        logic       en;
        logic       up;
        logic       load;
        logic [4:0] lv;
        logic [4:0] out;
        logic       tick;
        logic       tc;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic e, input logic u, input logic l,
                       input int lv, input int o, input logic t, input logic c, input int n);
        vec_t v;
        v.rst = r; v.en = e; v.up = u; v.load = l;
        v.lv = 5'(lv); v.out = 5'(o); v.tick = t; v.tc = c;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%0d expected=%0d", name, idx, act, exp);
        end
    endtask

    initial begin
        int eo, et, ec;

        bus.en = 1'b0; bus.up = 1'b1; bus.load = 1'b0; bus.load_val = '0;
        bus1.en = 1'b1; bus1.up = 1'b1; bus1.load = 1'b0; bus1.load_val = '0;

        // Down-count wrap, clamp, load-vs-stb, en=0, rst-vs-load, mid-period load.
        add(1,0,0,0,0,  0,0,0,1);
        add(0,1,0,0,0,  0,0,0,3);
        add(0,1,0,0,0,  9,1,1,1);
        add(0,1,0,0,0,  9,0,0,3);
        add(0,1,0,0,0,  8,1,0,1);
        add(0,1,1,0,0,  8,0,0,1);
        add(0,1,1,1,15, 9,0,0,1);
        add(0,1,1,0,0,  9,0,0,3);
        add(0,1,1,1,0,  0,0,0,1);
        add(0,1,1,0,0,  0,0,0,3);
        add(0,1,1,0,0,  1,1,0,1);
        for (int k = 0; k < 3; k++) begin
            add(0,0,1,0,0, 1,0,0,3);
            add(0,0,1,0,0, 1,1,0,1);
        end
        add(1,1,1,1,5,  0,0,0,1);
        add(0,1,1,0,0,  0,0,0,3);
        add(0,1,1,0,0,  1,1,0,1);
        add(0,1,1,0,0,  1,0,0,3);
        add(0,1,1,0,0,  2,1,0,1);
        add(0,1,1,0,0,  2,0,0,3);
        add(0,1,1,0,0,  3,1,0,1);
        add(0,1,1,0,0,  3,0,0,1);
        add(0,1,1,1,7,  7,0,0,1);
        add(0,1,1,0,0,  7,0,0,3);
        add(0,1,1,0,0,  8,1,0,1);

        foreach (tbl[i]) begin
            rst = tbl[i].rst; bus.en = tbl[i].en; bus.up = tbl[i].up;
            bus.load = tbl[i].load; bus.load_val = tbl[i].lv;
            @(posedge clk_in); #1;
            check("tbl_out",  i, 32'(bus.out),  32'(tbl[i].out));
            check("tbl_tick", i, 32'(bus.tick), 32'(tbl[i].tick));
            check("tbl_tc",   i, 32'(bus.tc),   32'(tbl[i].tc));
        end

        // Up count from reset through the top of the range.
        rst = 1'b1; bus.load = 1'b0; bus.en = 1'b1; bus.up = 1'b1;
        @(posedge clk_in); #1;
        check("up_rst_out", 0, 32'(bus.out), 32'd0);
        rst = 1'b0;
        for (int e = 1; e <= 48; e++) begin
            @(posedge clk_in); #1;
`ifdef TICK_COUNTER_SAT_EN
            eo = (e / 4 > 9) ? 9 : e / 4;
            ec = ((e % 4 == 0) && (e / 4 >= 10)) ? 1 : 0;
`else
            eo = (e / 4) % 10;
            ec = (e == 40) ? 1 : 0;
`endif
            et = (e % 4 == 0) ? 1 : 0;
            check("up_out",  e, 32'(bus.out),  32'(eo));
            check("up_tick", e, 32'(bus.tick), 32'(et));
            check("up_tc",   e, 32'(bus.tc),   32'(ec));
        end

        // DIV=1: a step every cycle.
        rst = 1'b1;
        rst1 = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk_in); #1;
`ifdef TICK_COUNTER_SAT_EN
            eo = (k > 9) ? 9 : k;
            ec = (k >= 10) ? 1 : 0;
`else
            eo = k % 10;
            ec = (k % 10 == 0) ? 1 : 0;
`endif
            check("div1_out",  k, 32'(bus1.out),  32'(eo));
            check("div1_tick", k, 32'(bus1.tick), 32'd1);
            check("div1_tc",   k, 32'(bus1.tc),   32'(ec));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tick_counter.md
Name: tick_counter

Overview:
- Parametrised successor to the fixed divide-by-2^22 clock divider and 5-bit counter.
- The whole block runs on clk_in. The prescaler produces a one-cycle enable tick; no derived clock is generated.
- The counter is an up/down, modulo-N counter with synchronous load and a terminal-count pulse.
- It drives LED/display-style counters in board top levels and replaces ad-hoc slow-clock counters.

Parameters:
- WIDTH, 5, counter width in bits.
- MODULO, 32, count range is 0..MODULO-1. Legal range 2..2**WIDTH; the design elaborates with an error outside this range.
- DIV, 4194304, prescaler period in clk_in cycles. Must be >= 1; DIV=1 means a tick every cycle.
- PRE_W, $clog2(DIV) (minimum 1), prescaler width. Derived; do not override.

Ports:
- clk_in  in  1  system clock. All state is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  count enable, sampled on tick cycles only.
- up  in  1  direction: 1 = increment, 0 = decrement.
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  value loaded when load=1.
- out  out  WIDTH  current count, registered.
- tick  out  1  registered prescaler tick, one cycle wide.
- tc  out  1  terminal-count pulse, one cycle wide, registered.

Behaviour:
- Reset (rst=1 at an edge): pre=0, out=0, tick=0, tc=0. Reset overrides load, en and tick in the same cycle.
- Prescaler:
  - pre increments every cycle regardless of en.
  - The internal strobe stb = (pre==DIV-1). When stb=1, pre returns to 0 on the next edge.
  - The tick output is stb registered, so it is high in the same cycle that a stepped out value first appears.
- Load (load=1, rst=0):
  - out <= load_val if load_val < MODULO, otherwise out <= MODULO-1 (clamp).
  - pre <= 0, which restarts the tick phase. tick <= 0 and tc <= 0.
  - Load beats a simultaneous stb; no step occurs that cycle.
- Step (stb & en & !load):
  - up=1: if out==MODULO-1 then out<=0 and tc<=1, else out<=out+1.
  - up=0: if out==0 then out<=MODULO-1 and tc<=1, else out<=out-1.
- In every other cycle out holds and tc<=0.
- en=0 on a stb cycle: out holds; tick still pulses; tc stays 0.
- Latency:
  - From reset release with en=1, up=1, the first step lands on the DIV-th edge. out=1 and tick=1 are then visible.
  - A load is visible on out one edge after it is sampled. The next step follows DIV edges after that.
- Direction changes take effect at the next step; there is no glitch and no extra step.
- Arithmetic is WIDTH bits. When MODULO=2**WIDTH, the wrap equals natural overflow but still pulses tc.

Optional Feature:
- Macro TICK_COUNTER_SAT_EN.
- Defined: the counter saturates instead of wrapping.
  - A step up at MODULO-1 holds out and pulses tc.
  - A step down at 0 holds out and pulses tc.
  - tc pulses on every blocked step attempt.
- Undefined: wrap behaviour as specified above.
- All other behaviour is identical in both builds.

Decomposition:
- Package tick_counter_pkg holds:
  - a function that clamps load_val to MODULO-1;
  - a localparam helper for PRE_W (clog2 with minimum 1).
- Sub-module tick_gen holds the prescaler:
  - parameters DIV, PRE_W;
  - ports clk_in, rst, restart, stb.
- tick_counter instantiates one tick_gen and holds the count, tc and tick registers.

Test Plan (WIDTH=5, MODULO=10, DIV=4 unless noted):
- Reset, then en=1, up=1 -> out=1 at edge 4 and out=9 at edge 36. At edge 40, out=0 with tc=1 for exactly one cycle. tick is high every 4th cycle.
- Reset, then en=1, up=0 -> at edge 4 out=9 with tc=1. At edge 8 out=8 with tc=0.
- Count to 3, then pulse load with load_val=7 between ticks -> out=7 next cycle. The next step to 8 comes exactly 4 edges after the load edge.
- load_val=15 -> out=9 (clamp). Then load_val=0 together with a stb cycle -> out=0 and no step that cycle.
- en=0 across three tick periods -> out constant and tick still pulses. rst=1 together with load=1 and load_val=5 -> out=0, tc=0, and pre restarts.
- With TICK_COUNTER_SAT_EN defined, at out=9 with up=1 -> steps hold out at 9 and tc pulses on each tick. With DIV=1 -> a step on every cycle.
